cache_tag_ctrl: RTL and testbench
=================================

Name: cache_tag_ctrl

Overview:
- Synthesizable, parametrised set-associative cache tag/state controller. Generalises the cache simulator to arbitrary sets, ways, line size and address width.
- Stores tag, valid and dirty per line; no data storage.
- Uses a valid/ready request handshake and true-LRU replacement with per-line age counters.
- Issues write-back and fill requests to a memory port and keeps saturating statistics counters.
- Sits between the CPU-side trace/request driver and the memory model in the cache simulation environment.

Parameters:
- SETS, 64: number of sets; power of two, ≥2.
- ASSOC, 4: ways per set; power of two, ≥2.
- LINE_BYTES, 16: line size in bytes; power of two, ≥4.
- ADDR_W, 32: byte address width.
- STAT_W, 32: width of each statistics counter.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller accepts request
- req_rw  input  1  0=read, 1=write
- req_addr  input  ADDR_W  byte address
- resp_valid  output  1  one-cycle response pulse
- resp_hit  output  1  1=request hit; valid with resp_valid
- mem_req_valid  output  1  memory request present
- mem_req_ready  input  1  memory accepts request
- mem_req_wb  output  1  1=write-back of victim, 0=line fill
- mem_req_addr  output  ADDR_W  line-aligned address; offset bits are 0
- stat_accesses, stat_hits, stat_misses, stat_evictions, stat_writebacks  output  STAT_W each  statistics counters

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on reset.
- Address split: OFF_W=log2(LINE_BYTES); IDX_W=log2(SETS); TAG_W=ADDR_W-IDX_W-OFF_W.
  - index = req_addr[OFF_W+IDX_W-1:OFF_W]
  - tag = req_addr[ADDR_W-1:OFF_W+IDX_W]
- Reset state:
  - All valid and dirty bits 0; tags 0.
  - Age of way w = w, so ages are distinct and way ASSOC-1 is oldest.
  - State IDLE; req_ready=0 while reset is asserted.
  - resp_valid=0, resp_hit=0, mem_req_valid=0, mem_req_wb=0, mem_req_addr=0.
  - All stat_* = 0.
- FSM states: IDLE, LOOKUP, WB, FILL, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register rw and addr, then go to LOOKUP.
- LOOKUP (1 cycle):
  - Compare the registered tag against all ways of the set; hit = valid && tag equal.
  - Hit: go to RESP. On a write hit, set the dirty bit.
  - Miss, victim selection: lowest-numbered invalid way; otherwise the way with age == ASSOC-1.
  - Miss with victim valid and dirty: go to WB. Otherwise go to FILL.
- WB:
  - mem_req_valid=1, mem_req_wb=1, mem_req_addr={victim tag, index, 0}.
  - Go to FILL on mem_req_ready.
- FILL:
  - mem_req_valid=1, mem_req_wb=0, mem_req_addr={tag, index, 0}.
  - On mem_req_ready: victim tag=tag, valid=1, dirty=rw; go to RESP.
- Memory port stability: mem_req_valid/wb/addr are registered and held stable until the handshake completes. mem_req_valid falls the cycle after the handshake.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_hit=hit from LOOKUP. There is no response backpressure.
  - Go to IDLE.
- Latency, counted from the accept edge as cycle 0:
  - Hit: resp_valid in cycle 2.
  - Clean miss with mem_req_ready held high: FILL in cycle 2, resp_valid in cycle 3.
  - Dirty miss: WB cycle 2, FILL cycle 3, resp_valid cycle 4.
  - Each mem_req_ready stall adds one cycle.
- LRU update: applied on entry to RESP for the accessed or filled way a.
  - Every way with age < age[a] increments; age[a]=0.
  - Ages always remain a permutation of 0..ASSOC-1.
- Statistics, updated on entry to RESP:
  - accesses+1, plus hits+1 or misses+1.
  - evictions+1 when a valid victim was replaced; writebacks+1 when the WB handshake completed.
  - All counters saturate at 2^STAT_W-1.
- Reset mid-operation: aborts immediately. No response is produced, mem_req_valid drops asynchronously, and all lines become invalid.
- Throughput: at most one outstanding request. req_ready=0 in every state except IDLE.

Optional Feature:
- Macro: CACHE_WRITE_THROUGH_EN.
- Defined:
  - Write-through, no-write-allocate.
  - Write hit: LOOKUP→WB, issuing mem_req_wb=1 to the request's line address, then RESP. The dirty bit is never set.
  - Write miss: WB for the write, no FILL, no allocation, no LRU change, resp_hit=0.
  - stat_writebacks counts these write-through transfers; stat_evictions counts only read-miss replacements.
- Undefined: write-back, write-allocate, as described under Behaviour.

Test Plan:
- SETS=4, ASSOC=2, LINE_BYTES=16, ADDR_W=16 used throughout, so 0x0000, 0x0040 and 0x0080 all map to index 0.
- Cold read miss: read 0x0014 with mem_req_ready=1 → FILL with mem_req_addr=0x0010 at cycle 2, resp_valid at cycle 3 with resp_hit=0. Reread 0x001C → resp_hit=1 at cycle 2, no mem_req_valid.
- LRU: read 0x0000, 0x0040, 0x0000, then 0x0080 → 0x0080 replaces the 0x0040 way (stat_evictions=1). Next read 0x0000 → hit; read 0x0040 → miss.
- Dirty write-back: write 0x0000, write 0x0040, read 0x0080 → WB with addr 0x0000 and mem_req_wb=1, then FILL with addr 0x0080. stat_writebacks=1, stat_misses=3, resp at cycle 4.
- Memory backpressure: hold mem_req_ready=0 for 5 cycles during FILL → mem_req_valid and mem_req_addr stay stable, req_ready=0, resp_valid arrives 5 cycles late.
- Reset mid-FILL: assert reset → mem_req_valid=0 in the same cycle, no resp_valid, stat_*=0. Reread of a previously cached line → resp_hit=0.
- Saturation, STAT_W=4: 20 accesses to one line → stat_accesses=15, stat_hits=15, stat_misses=1.

Source files
------------

// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: set-associative tag/state controller with true-LRU replacement and saturating statistics.
// Define CACHE_WRITE_THROUGH_EN for write-through/no-write-allocate; default is write-back/write-allocate.
module cache_tag_ctrl #(
    parameter int SETS       = 64,
    parameter int ASSOC      = 4,
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 32,
    parameter int STAT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wb,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [STAT_W-1:0] stat_accesses,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_misses,
    output logic [STAT_W-1:0] stat_evictions,
    output logic [STAT_W-1:0] stat_writebacks
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W  = $clog2(ASSOC);
    localparam int LINE_W = ADDR_W - OFF_W;
`ifdef CACHE_WRITE_THROUGH_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOOKUP = 3'd1;
    localparam logic [2:0] WB     = 3'd2;
    localparam logic [2:0] FILL   = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    logic [2:0]        state;
    logic              r_rw;
    logic [LINE_W-1:0] r_line;
    logic              r_hit;
    logic              r_vic_valid;
    logic              r_wb_done;
    logic [WAY_W-1:0]  r_way;

    logic [TAG_W-1:0] tag_mem   [SETS][ASSOC];
    logic [WAY_W-1:0] age_mem   [SETS][ASSOC];
    logic [ASSOC-1:0] valid_mem [SETS];
    logic [ASSOC-1:0] dirty_mem [SETS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] victim_addr;
    logic              hit;
    logic              inv_found;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  old_way;
    logic [WAY_W-1:0]  victim;
    logic              enter_resp;
    logic              cur_hit;
    logic              lru_en;
    logic [WAY_W-1:0]  lru_way;
    logic              evict_inc;
    logic              wb_inc;
    logic              unused_off;

    assign unused_off  = ^req_addr[OFF_W-1:0];
    assign idx         = r_line[IDX_W-1:0];
    assign tag         = r_line[LINE_W-1:IDX_W];
    assign line_addr   = {r_line, {OFF_W{1'b0}}};
    assign victim_addr = {tag_mem[idx][victim], idx, {OFF_W{1'b0}}};
    assign req_ready   = (state == IDLE) && !reset;
    assign resp_valid  = (state == RESP);
    assign resp_hit    = (state == RESP) && r_hit;

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        hit       = 1'b0;
        inv_found = 1'b0;
        hit_way   = '0;
        inv_way   = '0;
        old_way   = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (valid_mem[idx][w] && tag_mem[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_mem[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_mem[idx][w] == WAY_W'(ASSOC - 1))
                old_way = WAY_W'(w);
        end
        victim = inv_found ? inv_way : old_way;
    end

    always_comb begin
        enter_resp = (state == LOOKUP && hit && !(WT && r_rw))
                  || (state == FILL && mem_req_ready)
                  || (WT && state == WB && mem_req_ready);
        cur_hit    = (state == LOOKUP) ? hit : r_hit;
        lru_way    = (state == LOOKUP) ? hit_way : r_way;
        lru_en     = enter_resp && !(WT && r_rw && !cur_hit);
        evict_inc  = enter_resp && state == FILL && r_vic_valid;
        wb_inc     = enter_resp && (r_wb_done || state == WB);
    end

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && v != '1) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            r_rw            <= 1'b0;
            r_line          <= '0;
            r_hit           <= 1'b0;
            r_vic_valid     <= 1'b0;
            r_wb_done       <= 1'b0;
            r_way           <= '0;
            mem_req_valid   <= 1'b0;
            mem_req_wb      <= 1'b0;
            mem_req_addr    <= '0;
            stat_accesses   <= '0;
            stat_hits       <= '0;
            stat_misses     <= '0;
            stat_evictions  <= '0;
            stat_writebacks <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                for (int w = 0; w < ASSOC; w++) begin
                    tag_mem[s][w] <= '0;
                    age_mem[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    r_rw   <= req_rw;
                    r_line <= req_addr[ADDR_W-1:OFF_W];
                    state  <= LOOKUP;
                end
                LOOKUP: begin
                    r_hit     <= hit;
                    r_wb_done <= 1'b0;
                    if (WT && r_rw) begin
                        // Write-through: forward the write itself, never allocate.
                        r_way         <= hit_way;
                        r_vic_valid   <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_req_wb    <= 1'b1;
                        mem_req_addr  <= line_addr;
                        state         <= WB;
                    end else if (hit) begin
                        r_way       <= hit_way;
                        r_vic_valid <= 1'b0;
                        state       <= RESP;
                        if (r_rw)
                            dirty_mem[idx][hit_way] <= 1'b1;
                    end else begin
                        r_way         <= victim;
                        r_vic_valid   <= valid_mem[idx][victim];
                        mem_req_valid <= 1'b1;
                        if (valid_mem[idx][victim] && dirty_mem[idx][victim]) begin
                            mem_req_wb   <= 1'b1;
                            mem_req_addr <= victim_addr;
                            state        <= WB;
                        end else begin
                            mem_req_wb   <= 1'b0;
                            mem_req_addr <= line_addr;
                            state        <= FILL;
                        end
                    end
                end
                WB: if (mem_req_ready) begin
                    r_wb_done     <= 1'b1;
                    mem_req_wb    <= 1'b0;
                    mem_req_valid <= !WT;
                    mem_req_addr  <= WT ? mem_req_addr : line_addr;
                    state         <= WT ? RESP : FILL;
                end
                FILL: if (mem_req_ready) begin
                    tag_mem[idx][r_way]   <= tag;
                    valid_mem[idx][r_way] <= 1'b1;
                    dirty_mem[idx][r_way] <= r_rw && !WT;
                    mem_req_valid         <= 1'b0;
                    mem_req_wb            <= 1'b0;
                    state                 <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (lru_en) begin
                for (int w = 0; w < ASSOC; w++)
                    age_mem[idx][w] <= (WAY_W'(w) == lru_way) ? '0
                                     : (age_mem[idx][w] < age_mem[idx][lru_way]) ? age_mem[idx][w] + 1'b1
                                     : age_mem[idx][w];
            end
            stat_accesses   <= sat_inc(stat_accesses, enter_resp);
            stat_hits       <= sat_inc(stat_hits, enter_resp && cur_hit);
            stat_misses     <= sat_inc(stat_misses, enter_resp && !cur_hit);
            stat_evictions  <= sat_inc(stat_evictions, evict_inc);
            stat_writebacks <= sat_inc(stat_writebacks, wb_inc);
        end
    end
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb_cache_tag_ctrl: directed scoreboard bench; responses and memory requests are checked by monitors.
module tb_cache_tag_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready, req_rw;
    logic [15:0] req_addr;
    logic        resp_valid, resp_hit;
    logic        mem_req_valid, mem_req_ready, mem_req_wb;
    logic [15:0] mem_req_addr;
    logic [31:0] st_acc, st_hit, st_miss, st_evict, st_wb;

    logic        s_req_valid, s_req_ready, s_req_rw;
    logic [15:0] s_req_addr;
    logic        s_resp_valid, s_resp_hit;
    logic        s_mem_req_valid, s_mem_req_wb;
    logic [15:0] s_mem_req_addr;
    logic [3:0]  s_acc, s_hit, s_miss, s_evict, s_wb;

    always #5 clk = ~clk;

    cache_tag_ctrl #(.SETS(4), .ASSOC(2), .LINE_BYTES(16), .ADDR_W(16), .STAT_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wb(mem_req_wb),
        .mem_req_addr(mem_req_addr), .stat_accesses(st_acc), .stat_hits(st_hit),
        .stat_misses(st_miss), .stat_evictions(st_evict), .stat_writebacks(st_wb)
    );

    cache_tag_ctrl #(.SETS(4), .ASSOC(2), .LINE_BYTES(16), .ADDR_W(16), .STAT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .req_valid(s_req_valid), .req_ready(s_req_ready), .req_rw(s_req_rw),
        .req_addr(s_req_addr), .resp_valid(s_resp_valid), .resp_hit(s_resp_hit),
        .mem_req_valid(s_mem_req_valid), .mem_req_ready(1'b1), .mem_req_wb(s_mem_req_wb),
        .mem_req_addr(s_mem_req_addr), .stat_accesses(s_acc), .stat_hits(s_hit),
        .stat_misses(s_miss), .stat_evictions(s_evict), .stat_writebacks(s_wb)
    );

    typedef struct { logic hit; int lat; } resp_t;
    typedef struct { logic wb; logic [15:0] addr; } mem_t;
    resp_t resp_q[$];
    mem_t  mem_q[$];
    int n_checks = 0, n_fail = 0, resp_seen = 0, cyc = 0, acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Latency is the index of the cycle holding the event, the accept cycle being 0.
    always @(negedge clk) begin
        resp_t r;
        mem_t  m;
        #1;
        if (req_valid && req_ready) acc_cyc = cyc + 1;
        if (resp_valid) begin
            resp_seen++;
            if (resp_q.size() == 0) check("unexpected_resp", 32'(resp_valid), 32'(0));
            else begin
                r = resp_q.pop_front();
                check("resp_hit", 32'(resp_hit), 32'(r.hit));
                check("resp_latency", 32'(cyc - acc_cyc + 1), 32'(r.lat));
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            if (mem_q.size() == 0) check("unexpected_mem_req", 32'(mem_req_addr), 32'hFFFF_FFFF);
            else begin
                m = mem_q.pop_front();
                check("mem_req_wb", 32'(mem_req_wb), 32'(m.wb));
                check("mem_req_addr", 32'(mem_req_addr), 32'(m.addr));
            end
        end
    end

    task automatic exp_mem(input logic wb, input logic [15:0] a);
        mem_q.push_back('{wb: wb, addr: a});
    endtask

    task automatic issue(input logic rw, input logic [15:0] a, input logic hit, input int lat);
        resp_q.push_back('{hit: hit, lat: lat});
        req_rw = rw; req_addr = a; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n0);
        int k = 0;
        while (resp_seen == n0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (resp_seen == n0) check("resp_timeout", 32'(resp_seen), 32'(n0 + 1));
    endtask

    task automatic xfer(input logic rw, input logic [15:0] a, input logic hit, input int lat);
        int n0 = resp_seen;
        issue(rw, a, hit, lat);
        wait_resp(n0);
    endtask

    task automatic check_stats(input int a, input int h, input int m, input int e, input int w);
        check("stat_accesses", st_acc, 32'(a));
        check("stat_hits", st_hit, 32'(h));
        check("stat_misses", st_miss, 32'(m));
        check("stat_evictions", st_evict, 32'(e));
        check("stat_writebacks", st_wb, 32'(w));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, k;
        req_valid = 0; req_rw = 0; req_addr = 0; mem_req_ready = 1;
        s_req_valid = 0; s_req_rw = 0; s_req_addr = 0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_hit", 32'(resp_hit), 0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 0);
        check("rst_mem_req_wb", 32'(mem_req_wb), 0);
        check("rst_mem_req_addr", 32'(mem_req_addr), 0);
        check_stats(0, 0, 0, 0, 0);
        reset = 0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 1);
        // cold miss then hit on the same line
        exp_mem(0, 16'h0010); xfer(0, 16'h0014, 0, 3);
        xfer(0, 16'h001C, 1, 2);
        check_stats(2, 1, 1, 0, 0);
        // LRU ordering in set 0
        exp_mem(0, 16'h0000); xfer(0, 16'h0000, 0, 3);
        exp_mem(0, 16'h0040); xfer(0, 16'h0040, 0, 3);
        xfer(0, 16'h0000, 1, 2);
        exp_mem(0, 16'h0080); xfer(0, 16'h0080, 0, 3);
        check_stats(6, 2, 4, 1, 0);
        xfer(0, 16'h0000, 1, 2);
        exp_mem(0, 16'h0040); xfer(0, 16'h0040, 0, 3);
        check_stats(8, 3, 5, 2, 0);
        reset = 1; @(negedge clk); reset = 0; @(negedge clk);
        // dirty victim write-back
        exp_mem(0, 16'h0000); xfer(1, 16'h0000, 0, 3);
        exp_mem(0, 16'h0040); xfer(1, 16'h0040, 0, 3);
        exp_mem(1, 16'h0000); exp_mem(0, 16'h0080); xfer(0, 16'h0080, 0, 4);
        check_stats(3, 0, 3, 1, 1);
        // five stalled FILL cycles
        mem_req_ready = 0;
        exp_mem(0, 16'h0110);
        n0 = resp_seen;
        issue(0, 16'h0110, 0, 8);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("stall_mem_valid", 32'(mem_req_valid), 1);
            check("stall_mem_addr", 32'(mem_req_addr), 32'h0110);
            check("stall_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        mem_req_ready = 1;
        wait_resp(n0);
        check_stats(4, 0, 4, 1, 1);
        // reset while FILL is stalled
        mem_req_ready = 0;
        req_rw = 0; req_addr = 16'h0220; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        check("fill_pending", 32'(mem_req_valid), 1);
        reset = 1;
        #1;
        check("async_mem_valid_drop", 32'(mem_req_valid), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        @(negedge clk);
        check_stats(0, 0, 0, 0, 0);
        reset = 0; mem_req_ready = 1;
        repeat (3) @(negedge clk);
        check("post_reset_resp_valid", 32'(resp_valid), 0);
        exp_mem(0, 16'h0080); xfer(0, 16'h0080, 0, 3);
        xfer(1, 16'h0080, 1, 2);
        exp_mem(0, 16'h00C0); xfer(0, 16'h00C0, 0, 3);
        exp_mem(1, 16'h0080); exp_mem(0, 16'h0040); xfer(0, 16'h0040, 0, 4);
        check_stats(4, 1, 3, 1, 1);
        // saturating counters on the 4-bit instance
        for (int i = 0; i < 20; i++) begin
            s_req_rw = 0; s_req_addr = 16'h0030; s_req_valid = 1;
            @(negedge clk);
            s_req_valid = 0;
            k = 0;
            while (!s_resp_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (!s_resp_valid) check("sat_resp_timeout", 32'(s_resp_valid), 1);
            @(negedge clk);
        end
        check("sat_accesses", 32'(s_acc), 15);
        check("sat_hits", 32'(s_hit), 15);
        check("sat_misses", 32'(s_miss), 1);
        check("resp_queue_drained", 32'(resp_q.size()), 0);
        check("mem_queue_drained", 32'(mem_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
